// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core -- 32-bit integer ALU for the execute stage of a MIPS-style core.
//
// Every output is registered: operands and opcode sampled on rising edge N
// appear on the outputs after edge N and are held until the next edge.
// No valid/ready handshake exists: every clock edge accepts a new operation,
// and multiply/divide are single-cycle combinational paths, so the block
// never stalls.
//
// Ports:
//   clk                   system clock, rising-edge active
//   reset                 synchronous active-low reset (0 = reset)
//   ALUOperation [3:0]    operation select
//   a, b [WIDTH-1:0]      operands
//   ALU_result            registered result
//   zero                  registered flag, 1 when ALU_result == 0
//   ALU_MULTorDIV_result  registered HI/LO pair; only MULTIPLY/DIVIDE write it
// ---------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   ALU_result,
    output logic               zero,
    output logic [2*WIDTH-1:0] ALU_MULTorDIV_result
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_AND  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SGE  = 4'b0011;
    localparam logic [3:0] OP_SGT  = 4'b0100;
    localparam logic [3:0] OP_SLE  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_MULT = 4'b0111;
    localparam logic [3:0] OP_DIV  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_SLL  = 4'b1011;
    localparam logic [3:0] OP_SRL  = 4'b1100;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};

    logic [WIDTH-1:0]   alu_result_d, alu_result_q;
    logic               zero_d, zero_q;
    logic [2*WIDTH-1:0] muldiv_d, muldiv_q;

    logic signed [WIDTH-1:0]   a_s, b_s;
    logic signed [2*WIDTH-1:0] a_ext, b_ext;
    logic [2*WIDTH-1:0]        product;
    logic [WIDTH-1:0]          quotient, remainder;
    logic [SHW-1:0]            shamt;

    assign a_s   = $signed(a);
    assign b_s   = $signed(b);
    assign shamt = b[SHW-1:0];

    // Sign-extend both operands to full product width so the 64-bit product
    // is the true signed product rather than a zero-extended one.
    assign a_ext   = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext   = {{WIDTH{b[WIDTH-1]}}, b};
    assign product = a_ext * b_ext;

    // The two cases where native division is undefined or overflows get
    // fixed, exception-free results; otherwise truncate toward zero and
    // let the remainder follow the sign of the dividend.
    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (b == '0) begin
            quotient  = MINUS_ONE;
            remainder = a;
        end else if (a == INT_MIN && b == MINUS_ONE) begin
            quotient  = INT_MIN;
            remainder = '0;
        end else begin
            quotient  = a_s / b_s;
            remainder = a_s % b_s;
        end
    end

    always_comb begin
        alu_result_d = '0;
        muldiv_d     = muldiv_q;   // HI/LO hold unless MULT/DIV writes them
        unique case (ALUOperation)
            OP_ADD:  alu_result_d = a + b;
            OP_AND:  alu_result_d = a & b;
            OP_SUB:  alu_result_d = a - b;
            OP_OR:   alu_result_d = a | b;
            OP_XOR:  alu_result_d = a ^ b;
            // Set ops compare b against a (operand order is intentional).
            OP_SGE:  alu_result_d = {{(WIDTH-1){1'b0}}, (b_s >= a_s)};
            OP_SGT:  alu_result_d = {{(WIDTH-1){1'b0}}, (b_s >  a_s)};
            OP_SLE:  alu_result_d = {{(WIDTH-1){1'b0}}, (b_s <= a_s)};
            OP_SLT:  alu_result_d = {{(WIDTH-1){1'b0}}, (b_s <  a_s)};
            OP_MULT: begin
                alu_result_d = product[WIDTH-1:0];
                muldiv_d     = product;
            end
            OP_DIV: begin
                alu_result_d = quotient;
                muldiv_d     = {remainder, quotient};
            end
            OP_SLL:  alu_result_d = a << shamt;
            OP_SRL:  alu_result_d = a >> shamt;
            OP_SRA:  alu_result_d = a_s >>> shamt;
            default: alu_result_d = '0;
        endcase
        zero_d = (alu_result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_result_q <= '0;
            zero_q       <= 1'b1;
            muldiv_q     <= '0;
        end else begin
            alu_result_q <= alu_result_d;
            zero_q       <= zero_d;
            muldiv_q     <= muldiv_d;
        end
    end

    assign ALU_result           = alu_result_q;
    assign zero                 = zero_q;
    assign ALU_MULTorDIV_result = muldiv_q;

endmodule

// File: tb/tb_alu_core.sv
// ---------------------------------------------------------------------------
// tb_alu_core -- directed, table-driven bench for alu_core.
// Each vector carries hand-computed expected outputs; expected values are
// pushed into a queue when a vector is driven and popped when the
// registered outputs are checked one edge later.
// ---------------------------------------------------------------------------
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [3:0]  ALUOperation;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ALU_result;
    logic        zero;
    logic [63:0] ALU_MULTorDIV_result;

    alu_core #(.WIDTH(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .ALUOperation         (ALUOperation),
        .a                    (a),
        .b                    (b),
        .ALU_result           (ALU_result),
        .zero                 (zero),
        .ALU_MULTorDIV_result (ALU_MULTorDIV_result)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_mis = 0;

    // {result[31:0], zero, md[63:0]}
    logic [96:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string name);
        logic [96:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_mis++;
            $display("FAIL %s: actual=empty_queue required=expected_entry", name);
        end else begin
            e = exp_q.pop_front();
            check({name, ".result"}, {32'd0, ALU_result}, {32'd0, e[96:65]});
            check({name, ".zero"},   {63'd0, zero},       {63'd0, e[64]});
            check({name, ".md"},     ALU_MULTorDIV_result, e[63:0]);
        end
    endtask

    // ---------------- driver ----------------
    // Called away from the edge; drives, lets one rising edge sample, then
    // checks 2 time units later.
    task automatic step(input string name, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] res, input logic z,
                        input logic [63:0] md);
        ALUOperation = op;
        a            = va;
        b            = vb;
        exp_q.push_back({res, z, md});
        @(posedge clk);
        #2;
        check_outputs(name);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic [63:0] md;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [3:0] op, input logic [31:0] va,
                                input logic [31:0] vb, input logic [31:0] res, input logic z,
                                input logic [63:0] md);
        vec_t v;
        v.name = n; v.op = op; v.a = va; v.b = vb; v.res = res; v.z = z; v.md = md;
        return v;
    endfunction

    initial begin
        reset        = 1'b0;
        ALUOperation = 4'b0000;
        a            = 32'd0;
        b            = 32'd0;

        // Arithmetic and logic; md starts at 0 after reset and must hold.
        vecs.push_back(mk("add",      4'b0000, 32'd10, 32'd2, 32'd12, 1'b0, 64'd0));
        vecs.push_back(mk("sub",      4'b0010, 32'd10, 32'd2, 32'd8,  1'b0, 64'd0));
        vecs.push_back(mk("sub_zero", 4'b0010, 32'd5,  32'd5, 32'd0,  1'b1, 64'd0));
        vecs.push_back(mk("and",      4'b0001, 32'h00FF, 32'h10F0, 32'h00F0, 1'b0, 64'd0));
        vecs.push_back(mk("or",       4'b1001, 32'h00FF, 32'h10F0, 32'h10FF, 1'b0, 64'd0));
        vecs.push_back(mk("xor",      4'b1010, 32'h00FF, 32'h10F0, 32'h100F, 1'b0, 64'd0));
        vecs.push_back(mk("add_wrap", 4'b0000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 64'd0));
        // Multiply / divide and HI/LO hold
        vecs.push_back(mk("mul",      4'b0111, 32'd10, 32'd2, 32'd20, 1'b0, 64'd20));
        vecs.push_back(mk("div",      4'b1000, 32'd10, 32'd2, 32'd5,  1'b0, 64'd5));
        vecs.push_back(mk("add_hold", 4'b0000, 32'd10, 32'd2, 32'd12, 1'b0, 64'd5));
        vecs.push_back(mk("div_neg",  4'b1000, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0,
                          64'hFFFFFFFF_FFFFFFFD));
        vecs.push_back(mk("mul_big",  4'b0111, 32'h10000, 32'h10000, 32'd0, 1'b1,
                          64'h00000001_00000000));
        vecs.push_back(mk("div_by0",  4'b1000, 32'd7, 32'd0, 32'hFFFFFFFF, 1'b0,
                          64'h00000007_FFFFFFFF));
        vecs.push_back(mk("div_ovf",  4'b1000, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0,
                          64'h00000000_80000000));
        // Set ops (b compared against a)
        vecs.push_back(mk("sgt",      4'b0100, 32'd10, 32'd2, 32'd0, 1'b1, 64'h00000000_80000000));
        vecs.push_back(mk("slt",      4'b0110, 32'd10, 32'd2, 32'd1, 1'b0, 64'h00000000_80000000));
        vecs.push_back(mk("sge",      4'b0011, 32'd10, 32'd2, 32'd0, 1'b1, 64'h00000000_80000000));
        vecs.push_back(mk("sle",      4'b0101, 32'd10, 32'd2, 32'd1, 1'b0, 64'h00000000_80000000));
        vecs.push_back(mk("slt_sgn",  4'b0110, 32'd2, 32'hFFFFFFFF, 32'd1, 1'b0,
                          64'h00000000_80000000));
        // Shifts
        vecs.push_back(mk("sll",      4'b1011, 32'h80000040, 32'd2, 32'h00000100, 1'b0,
                          64'h00000000_80000000));
        vecs.push_back(mk("srl",      4'b1100, 32'h80000040, 32'd2, 32'h20000010, 1'b0,
                          64'h00000000_80000000));
        vecs.push_back(mk("sra",      4'b1101, 32'h80000040, 32'd2, 32'hE0000010, 1'b0,
                          64'h00000000_80000000));
        vecs.push_back(mk("sll_hib",  4'b1011, 32'h80000040, 32'h22, 32'h00000100, 1'b0,
                          64'h00000000_80000000));
        vecs.push_back(mk("sra_pos",  4'b1101, 32'h40000000, 32'd31, 32'd0, 1'b1,
                          64'h00000000_80000000));
        // Signed multiply / divide with negative operands
        vecs.push_back(mk("mul_neg",  4'b0111, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1, 1'b0,
                          64'hFFFFFFFF_FFFFFFF1));
        vecs.push_back(mk("div_nn",   4'b1000, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3, 1'b0,
                          64'hFFFFFFFF_00000003));
        // Equal-operand set-op boundary
        vecs.push_back(mk("sge_eq",   4'b0011, 32'd4, 32'd4, 32'd1, 1'b0, 64'hFFFFFFFF_00000003));
        vecs.push_back(mk("sgt_eq",   4'b0100, 32'd4, 32'd4, 32'd0, 1'b1, 64'hFFFFFFFF_00000003));
        vecs.push_back(mk("sle_eq",   4'b0101, 32'd4, 32'd4, 32'd1, 1'b0, 64'hFFFFFFFF_00000003));
        vecs.push_back(mk("slt_eq",   4'b0110, 32'd4, 32'd4, 32'd0, 1'b1, 64'hFFFFFFFF_00000003));
        // Unused opcodes
        vecs.push_back(mk("op_1110",  4'b1110, 32'd5, 32'd3, 32'd0, 1'b1, 64'hFFFFFFFF_00000003));
        vecs.push_back(mk("op_1111",  4'b1111, 32'd5, 32'd3, 32'd0, 1'b1, 64'hFFFFFFFF_00000003));

        // ---- reset for two cycles, checked after each edge ----
        @(negedge clk);
        ALUOperation = 4'b0111;
        a            = 32'd9;
        b            = 32'd9;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({32'd0, 1'b1, 64'd0});
            @(posedge clk);
            #2;
            check_outputs("reset");
        end
        reset = 1'b1;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].res, vecs[i].z, vecs[i].md);
        end

        // ---- reset on the same edge as an in-flight multiply ----
        ALUOperation = 4'b0111;
        a            = 32'd10;
        b            = 32'd3;
        reset        = 1'b0;
        exp_q.push_back({32'd0, 1'b1, 64'd0});
        @(posedge clk);
        #2;
        check_outputs("rst_mid_mul");
        reset = 1'b1;

        // ---- short reset pulse between edges must be ignored ----
        step("mul_pre", 4'b0111, 32'd10, 32'd2, 32'd20, 1'b0, 64'd20);
        ALUOperation = 4'b0000;
        a            = 32'd3;
        b            = 32'd4;
        #1 reset = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("pulse_hold.result", {32'd0, ALU_result}, 64'd20);
        check("pulse_hold.md", ALU_MULTorDIV_result, 64'd20);
        exp_q.push_back({32'd7, 1'b0, 64'd20});
        @(posedge clk);
        #2;
        check_outputs("pulse_next");

        check("queue_drained", {32'd0, exp_q.size()}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the MIPS-style CPU datapath.
- Takes operands a and b and a 4-bit operation code.
- Produces a registered 32-bit result, a zero flag, and a registered 64-bit multiply/divide result (HI/LO pair).
- Sits in the execute stage; all outputs update on the rising clock edge one cycle after the operands are sampled.

Parameters:
- WIDTH, 32, operand/result width (only 32 needs support; product/quotient port is 2*WIDTH).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- ALUOperation  input  4  operation select.
- a  input  32  operand A.
- b  input  32  operand B.
- ALU_result  output  32  registered result.
- zero  output  1  registered flag, 1 when ALU_result == 0.
- ALU_MULTorDIV_result  output  64  registered multiply/divide result.

Behaviour:
- Reset (reset==0 at rising clk): ALU_result=0, zero=1, ALU_MULTorDIV_result=0. Reset has priority over any operation, including mid-stream.
- Latency: exactly 1 cycle. Inputs are sampled at rising edge N; outputs are valid after edge N and held until the next edge.
- The zero output is registered and always equals (ALU_result == 0) for the same cycle.
- Opcodes; all arithmetic is 32-bit and wraps modulo 2^32, with no overflow trap:
  - 0000 ADD: a + b.
  - 0001 AND: a & b.
  - 0010 SUBTRACT: a - b.
  - 1001 OR: a | b.
  - 1010 XOR: a ^ b.
- Set operations compare b against a as signed two's-complement; the result is 32'd1 if true, else 0:
  - 0011 SET_GREATER_OR_EQUAL: b >= a.
  - 0100 SET_ON_GREATER_THAN: b > a.
  - 0101 SET_LESS_OR_EQUAL: b <= a.
  - 0110 SET_ON_LESS_THAN: b < a.
- 0111 MULTIPLY:
  - Full signed 64-bit product a*b goes to ALU_MULTorDIV_result.
  - ALU_result = product[31:0].
- 1000 DIVIDE:
  - Signed a/b, truncating toward zero.
  - ALU_MULTorDIV_result = {remainder, quotient}; remainder takes the sign of a.
  - ALU_result = quotient.
  - b==0: quotient=32'hFFFFFFFF, remainder=a, no exception.
  - a=32'h80000000, b=-1: quotient=32'h80000000, remainder=0.
- Shifts (shift amount = b[4:0]; upper bits of b ignored):
  - 1011 SHIFT_LEFT: a << b[4:0].
  - 1100 SHIFT_RIGHT: logical a >> b[4:0].
  - 1101 SHIFT_RIGHT_SIGNED: arithmetic a >>> b[4:0], sign bit replicated.
- Unused codes 1110, 1111: ALU_result=0, zero=1.
- ALU_MULTorDIV_result updates only on MULTIPLY or DIVIDE; for every other opcode it holds its previous value (HI/LO semantics).
- Single-cycle combinational multiply/divide feeding the output registers; no stall or handshake.

Test Plan:
- Reset and basic arithmetic:
  - reset=0 for 2 cycles -> ALU_result=0, zero=1, ALU_MULTorDIV_result=0.
  - Release, a=10, b=2, ADD -> 12 after next edge; SUBTRACT -> 8, zero=0.
  - a=b=5, SUBTRACT -> 0, zero=1.
- Logic ops: a=32'h00FF, b=32'h10F0:
  - AND -> 32'h00F0.
  - OR -> 32'h10FF.
  - XOR -> 32'h100F.
- Multiply/divide, a=10, b=2:
  - MULTIPLY -> ALU_result=20, ALU_MULTorDIV_result=64'd20.
  - DIVIDE -> ALU_result=5, ALU_MULTorDIV_result={32'd0, 32'd5}.
  - Then ADD -> ALU_MULTorDIV_result unchanged.
  - a=-7, b=2, DIVIDE -> quotient 32'hFFFFFFFD, remainder 32'hFFFFFFFF.
  - a=32'h10000, b=32'h10000, MULTIPLY -> 64'h1_00000000, ALU_result=0, zero=1.
  - b=0, DIVIDE -> quotient 32'hFFFFFFFF, remainder=a.
- Set ops with a=10, b=2:
  - SET_ON_GREATER_THAN -> 0 (zero=1).
  - SET_ON_LESS_THAN -> 1 (zero=0).
  - SET_GREATER_OR_EQUAL -> 0.
  - SET_LESS_OR_EQUAL -> 1.
  - a=2, b=-1 (32'hFFFFFFFF), SET_ON_LESS_THAN -> 1 (signed compare).
- Shifts, a=32'h80000040:
  - b=2, SHIFT_LEFT -> 32'h00000100.
  - b=2, SHIFT_RIGHT -> 32'h20000010.
  - b=2, SHIFT_RIGHT_SIGNED -> 32'hE0000010.
  - b=32'h22 (amount 2), SHIFT_LEFT -> 32'h00000100.
- Synchronous reset mid-operation:
  - MULTIPLY in flight, assert reset=0 on the same edge -> all outputs reset values.
  - Asynchronous pulse of reset low between edges -> no effect.
